// File: rtl/ct_ifu_icache_pkg.sv
// Shared types and defaults for the ICache data array.
// ICACHE_DATA_PARITY_EN widens every bank entry by one even-parity bit.
package ct_ifu_icache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    INIT = 1'b1
  } fsm_state_e;

  localparam int DEF_BANK_NUM = 4;
  localparam int DEF_BANK_DW  = 32;
  localparam int DEF_INDEX_W  = 10;
  localparam int DEF_RD_PIPE  = 0;

`ifdef ICACHE_DATA_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

endpackage

// File: rtl/ct_ifu_icache_data_bank.sv
// One ICache data bank: clock gate, single-port array, output stage and parity check.
// ICACHE_DATA_PARITY_EN stores and checks an even-parity bit per entry.
module ct_ifu_icache_data_bank
  import ct_ifu_icache_pkg::*;
#(
  parameter int BANK_DW = DEF_BANK_DW,
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int RD_PIPE = DEF_RD_PIPE
) (
  input  logic               clk_i,
  input  logic               rst_b_i,
  input  logic               global_en_i,
  input  logic               module_en_i,
  input  logic               scan_en_i,
  input  logic               cen_b_i,
  input  logic               gwen_b_i,
  input  logic [INDEX_W-1:0] addr_i,
  input  logic [BANK_DW-1:0] wdata_i,
  input  logic               rd_gnt_i,
  input  logic               rd_sel_i,
  output logic [BANK_DW-1:0] dout_o,
  output logic               parity_err_o
);

  localparam int WORD_W = BANK_DW + PAR_W;
  localparam int DEPTH  = 1 << INDEX_W;

  logic              gclk;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;
  logic [WORD_W-1:0] wword;
  logic              sel_q;
  logic [BANK_DW-1:0] data1;
  logic              err1;

  gated_clk_cell u_icg (
    .clk_in             (clk_i),
    .global_en          (global_en_i),
    .module_en          (module_en_i),
    .local_en           (~cen_b_i),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (scan_en_i),
    .clk_out            (gclk)
  );

`ifdef ICACHE_DATA_PARITY_EN
  assign wword = {^wdata_i, wdata_i};
  assign err1  = sel_q & (^rdata_q);
`else
  assign wword = wdata_i;
  assign err1  = 1'b0;
`endif

  // Read data only changes on a read, so the output holds between reads.
  always_ff @(posedge gclk) begin
    if (!cen_b_i) begin
      if (!gwen_b_i) begin
        mem_q[addr_i] <= wword;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      sel_q <= 1'b0;
    end else if (rd_gnt_i) begin
      sel_q <= rd_sel_i;
    end
  end

  assign data1 = sel_q ? rdata_q[BANK_DW-1:0] : '0;

  if (RD_PIPE != 0) begin : g_pipe
    logic               rd1_q;
    logic [BANK_DW-1:0] dout_q;
    logic               err_q;

    always_ff @(posedge clk_i) begin
      if (!rst_b_i) begin
        rd1_q  <= 1'b0;
        dout_q <= '0;
        err_q  <= 1'b0;
      end else begin
        rd1_q <= rd_gnt_i;
        if (rd1_q) begin
          dout_q <= data1;
          err_q  <= err1;
        end
      end
    end

    assign dout_o       = dout_q;
    assign parity_err_o = err_q;
  end else begin : g_nopipe
    assign dout_o       = data1;
    assign parity_err_o = err1;
  end

endmodule

// File: rtl/gated_clk_cell.sv
// Latch-based integrated clock gate used in front of each SRAM bank.
module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);

  logic clk_en_bf_latch;
  logic clk_en_af_latch;

  assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

  // Enable is captured while the clock is low so clk_out never glitches.
  always_latch begin
    if (!clk_in) begin
      clk_en_af_latch <= clk_en_bf_latch | pad_yy_icg_scan_en;
    end
  end

  assign clk_out = clk_in & clk_en_af_latch;

endmodule

// File: rtl/ct_ifu_icache_data_array_pbank.sv
// ICache data array top: init sweep FSM, write-priority arbitration, BANK_NUM gated banks.
// ICACHE_DATA_PARITY_EN enables per-bank parity error reporting on rd_parity_err_o.
module ct_ifu_icache_data_array_pbank
  import ct_ifu_icache_pkg::*;
#(
  parameter int BANK_NUM = DEF_BANK_NUM,
  parameter int BANK_DW  = DEF_BANK_DW,
  parameter int INDEX_W  = DEF_INDEX_W,
  parameter int RD_PIPE  = DEF_RD_PIPE
) (
  input  logic                        forever_cpuclk_i,
  input  logic                        cpurst_b_i,
  input  logic                        cp0_yy_clk_en_i,
  input  logic                        cp0_ifu_icg_en_i,
  input  logic                        pad_yy_icg_scan_en_i,
  input  logic                        init_req_i,
  output logic                        init_busy_o,
  input  logic                        rd_req_i,
  input  logic [INDEX_W-1:0]          rd_index_i,
  input  logic [BANK_NUM-1:0]         rd_bank_mask_i,
  output logic                        rd_gnt_o,
  output logic                        rd_dout_vld_o,
  output logic [BANK_NUM*BANK_DW-1:0] rd_dout_o,
  input  logic                        wr_req_i,
  input  logic [INDEX_W-1:0]          wr_index_i,
  input  logic [BANK_NUM-1:0]         wr_bank_mask_i,
  input  logic [BANK_NUM*BANK_DW-1:0] wr_din_i,
  output logic                        wr_gnt_o,
  output logic [BANK_NUM-1:0]         rd_parity_err_o
);

  localparam logic [INDEX_W-1:0] LAST_IDX = '1;

  fsm_state_e         state_q, state_d;
  logic [INDEX_W-1:0] init_cnt_q, init_cnt_d;
  logic               sweep;
  logic [INDEX_W-1:0] addr;
  logic               rd_vld1_q;
  logic [BANK_NUM-1:0] bank_perr;

  always_ff @(posedge forever_cpuclk_i) begin
    if (!cpurst_b_i) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      rd_vld1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rd_vld1_q  <= rd_gnt_o;
    end
  end

  // init_req during a sweep is ignored; the counter wraps to 0 on the last index.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (init_req_i) begin
          state_d    = INIT;
          init_cnt_d = '0;
        end
      end
      default: begin
        state_d    = INIT;
        init_cnt_d = '0;
      end
    endcase
  end

  assign sweep       = (state_q == INIT);
  assign init_busy_o = sweep;
  assign wr_gnt_o    = ~sweep & wr_req_i;
  assign rd_gnt_o    = ~sweep & rd_req_i & ~wr_req_i;
  assign addr        = sweep ? init_cnt_q : (wr_gnt_o ? wr_index_i : rd_index_i);

  if (RD_PIPE != 0) begin : g_vld_pipe
    logic rd_vld2_q;
    always_ff @(posedge forever_cpuclk_i) begin
      if (!cpurst_b_i) begin
        rd_vld2_q <= 1'b0;
      end else begin
        rd_vld2_q <= rd_vld1_q;
      end
    end
    assign rd_dout_vld_o = rd_vld2_q;
  end else begin : g_vld_nopipe
    assign rd_dout_vld_o = rd_vld1_q;
  end

  assign rd_parity_err_o = bank_perr & {BANK_NUM{rd_dout_vld_o}};

  // Bank 0 sits in the MSBs of every data bus and mask.
  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    localparam int MSB  = (BANK_NUM - b) * BANK_DW - 1;
    localparam int MBIT = BANK_NUM - 1 - b;

    logic               wr_sel;
    logic               rd_sel;
    logic [BANK_DW-1:0] wdata;

    assign wr_sel = sweep | (wr_gnt_o & wr_bank_mask_i[MBIT]);
    assign rd_sel = rd_gnt_o & rd_bank_mask_i[MBIT];
    assign wdata  = sweep ? '0 : wr_din_i[MSB -: BANK_DW];

    ct_ifu_icache_data_bank #(
      .BANK_DW (BANK_DW),
      .INDEX_W (INDEX_W),
      .RD_PIPE (RD_PIPE)
    ) u_bank (
      .clk_i        (forever_cpuclk_i),
      .rst_b_i      (cpurst_b_i),
      .global_en_i  (cp0_yy_clk_en_i),
      .module_en_i  (cp0_ifu_icg_en_i),
      .scan_en_i    (pad_yy_icg_scan_en_i),
      .cen_b_i      (~(wr_sel | rd_sel)),
      .gwen_b_i     (~wr_sel),
      .addr_i       (addr),
      .wdata_i      (wdata),
      .rd_gnt_i     (rd_gnt_o),
      .rd_sel_i     (rd_sel),
      .dout_o       (rd_dout_o[MSB -: BANK_DW]),
      .parity_err_o (bank_perr[MBIT])
    );
  end

endmodule

// File: tb/tb_ct_ifu_icache_data_array_pbank.sv
// Self-checking bench for ct_ifu_icache_data_array_pbank (4 banks x 16 entries).
// With ICACHE_DATA_PARITY_EN defined, a corrupted entry is checked for a parity error.
module tb_ct_ifu_icache_data_array_pbank;

  localparam int BANK_NUM = 4;
  localparam int BANK_DW  = 32;
  localparam int INDEX_W  = 4;
  localparam int RD_PIPE  = 0;
  localparam int DEPTH    = 16;

  localparam logic [127:0] DATA_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] DATA_C = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] DATA_D = 128'hCAFE_0001_CAFE_0002_CAFE_0003_CAFE_0004;
  localparam logic [127:0] DATA_E = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;

  logic         clk;
  logic         rst_b;
  logic         clkEn;
  logic         icgEn;
  logic         scanEn;
  logic         initReq;
  logic         initBusy;
  logic         rdReq;
  logic [3:0]   rdIndex;
  logic [3:0]   rdMask;
  logic         rdGnt;
  logic         rdVld;
  logic [127:0] rdDout;
  logic         wrReq;
  logic [3:0]   wrIndex;
  logic [3:0]   wrMask;
  logic [127:0] wrDin;
  logic         wrGnt;
  logic [3:0]   rdPerr;

  int checkCount = 0;
  int errorCount = 0;

  ct_ifu_icache_data_array_pbank #(
    .BANK_NUM (BANK_NUM),
    .BANK_DW  (BANK_DW),
    .INDEX_W  (INDEX_W),
    .RD_PIPE  (RD_PIPE)
  ) dut (
    .forever_cpuclk_i     (clk),
    .cpurst_b_i           (rst_b),
    .cp0_yy_clk_en_i      (clkEn),
    .cp0_ifu_icg_en_i     (icgEn),
    .pad_yy_icg_scan_en_i (scanEn),
    .init_req_i           (initReq),
    .init_busy_o          (initBusy),
    .rd_req_i             (rdReq),
    .rd_index_i           (rdIndex),
    .rd_bank_mask_i       (rdMask),
    .rd_gnt_o             (rdGnt),
    .rd_dout_vld_o        (rdVld),
    .rd_dout_o            (rdDout),
    .wr_req_i             (wrReq),
    .wr_index_i           (wrIndex),
    .wr_bank_mask_i       (wrMask),
    .wr_din_i             (wrDin),
    .wr_gnt_o             (wrGnt),
    .rd_parity_err_o      (rdPerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: memory contents per bank, remaining sweep cycles, read-result pipeline.
  typedef struct {
    logic         vld;
    logic [127:0] data;
    logic [3:0]   perr;
  } rdEntry_t;

  logic [31:0]  modelMem [4][DEPTH];
  bit           corrupt  [4][DEPTH];
  rdEntry_t     pipeQ[$];
  bit           modelValid = 0;
  int           initLeft   = 0;
  logic         expVld     = 1'b0;
  logic [127:0] expDout    = '0;
  logic [3:0]   expPerr    = '0;

  always @(negedge clk) begin
    rdEntry_t e;
    rdEntry_t o;
    logic expBusy;
    logic expWg;
    logic expRg;
    expBusy = (initLeft > 0);
    expWg   = !expBusy && wrReq;
    expRg   = !expBusy && rdReq && !wrReq;
    if (modelValid) begin
      checkOutput("init_busy", initBusy, expBusy);
      checkOutput("wr_gnt", wrGnt, expWg);
      checkOutput("rd_gnt", rdGnt, expRg);
      checkOutput("rd_dout_vld", rdVld, expVld);
      checkOutput("rd_dout", rdDout, expDout);
      checkOutput("rd_parity_err", rdPerr, expVld ? expPerr : 4'b0);
    end
    if (!rst_b) begin
      modelValid = 1;
      initLeft   = DEPTH;
      pipeQ.delete();
      expVld  = 1'b0;
      expDout = '0;
      expPerr = '0;
    end else if (modelValid) begin
      e.vld  = 1'b0;
      e.data = '0;
      e.perr = '0;
      if (expBusy) begin
        for (int b = 0; b < 4; b++) begin
          modelMem[b][DEPTH-initLeft] = '0;
          corrupt[b][DEPTH-initLeft]  = 0;
        end
        initLeft--;
      end else begin
        if (expRg) begin
          e.vld = 1'b1;
          for (int b = 0; b < 4; b++) begin
            if (rdMask[3-b]) begin
              e.data[(4-b)*32-1 -: 32] = modelMem[b][rdIndex];
              e.perr[3-b]              = corrupt[b][rdIndex];
            end
          end
        end
        if (expWg) begin
          for (int b = 0; b < 4; b++) begin
            if (wrMask[3-b]) begin
              modelMem[b][wrIndex] = wrDin[(4-b)*32-1 -: 32];
              corrupt[b][wrIndex]  = 0;
            end
          end
        end
        if (initReq) initLeft = DEPTH;
      end
      pipeQ.push_back(e);
      if (pipeQ.size() > RD_PIPE) begin
        o = pipeQ.pop_front();
        expVld = o.vld;
        if (o.vld) begin
          expDout = o.data;
          expPerr = o.perr;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rr, input logic [3:0] ri, input logic [3:0] rm,
                               input logic wr, input logic [3:0] wi, input logic [3:0] wm,
                               input logic [127:0] wd, input logic ir);
    rdReq   = rr;
    rdIndex = ri;
    rdMask  = rm;
    wrReq   = wr;
    wrIndex = wi;
    wrMask  = wm;
    wrDin   = wd;
    initReq = ir;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, '0, 1'b0);
  endtask

  task automatic readAndCheck(input string name, input logic [3:0] idx, input logic [3:0] mask,
                              input logic [127:0] expData, input logic [3:0] expPe);
    applyStimulus(1'b1, idx, mask, 1'b0, 4'd0, 4'd0, '0, 1'b0);
    tick();
    idle();
    repeat (RD_PIPE) tick();
    @(negedge clk);
    checkOutput({name, "_vld"}, rdVld, 1'b1);
    checkOutput({name, "_dout"}, rdDout, expData);
    checkOutput({name, "_perr"}, rdPerr, expPe);
    tick();
  endtask

  task automatic countBusy(output int n);
    n = 0;
    @(negedge clk);
    while (initBusy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_b  = 1'b0;
    clkEn  = 1'b1;
    icgEn  = 1'b0;
    scanEn = 1'b0;
    idle();
    repeat (3) tick();

    @(negedge clk);
    checkOutput("reset_init_busy", initBusy, 1'b1);
    checkOutput("reset_rd_dout", rdDout, 128'h0);
    checkOutput("reset_rd_vld", rdVld, 1'b0);
    checkOutput("reset_perr", rdPerr, 4'h0);
    tick();
    rst_b = 1'b1;

    countBusy(n);
    checkOutput("init_busy_cycles", n, 16);
    tick();

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 4'(i), 4'hF, 1'b0, 4'd0, 4'd0, '0, 1'b0);
      tick();
    end
    idle();
    readAndCheck("init_zero_idx9", 4'd9, 4'hF, 128'h0, 4'h0);

    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd5, 4'hF, DATA_A, 1'b0);
    tick();
    readAndCheck("raw_idx5", 4'd5, 4'hF, DATA_A, 4'h0);

    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd3, 4'b0010,
                  128'hAAAAAAAA_BBBBBBBB_DEADBEEF_CCCCCCCC, 1'b0);
    tick();
    readAndCheck("partial_idx3", 4'd3, 4'b0110, 128'h00000000_00000000_DEADBEEF_00000000, 4'h0);

    applyStimulus(1'b1, 4'd7, 4'hF, 1'b1, 4'd7, 4'hF, DATA_C, 1'b0);
    @(negedge clk);
    checkOutput("coll_wr_gnt", wrGnt, 1'b1);
    checkOutput("coll_rd_gnt", rdGnt, 1'b0);
    tick();
    readAndCheck("coll_retry_idx7", 4'd7, 4'hF, DATA_C, 4'h0);
    @(negedge clk);
    checkOutput("hold_vld", rdVld, 1'b0);
    checkOutput("hold_dout", rdDout, DATA_C);
    tick();

    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd5, 4'b0000, {128{1'b1}}, 1'b0);
    @(negedge clk);
    checkOutput("mask0_wr_gnt", wrGnt, 1'b1);
    tick();
    readAndCheck("mask0_idx5", 4'd5, 4'hF, DATA_A, 4'h0);

    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd15, 4'hF, DATA_D, 1'b0);
    tick();
    readAndCheck("top_idx15", 4'd15, 4'hF, DATA_D, 4'h0);
    readAndCheck("idx0_untouched", 4'd0, 4'hF, 128'h0, 4'h0);

    // Sweep on request, with requests held and a second init_req ignored mid-sweep.
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, '0, 1'b1);
    tick();
    applyStimulus(1'b1, 4'd9, 4'hF, 1'b1, 4'd9, 4'hF, DATA_E, 1'b0);
    @(negedge clk);
    checkOutput("init_wr_gnt", wrGnt, 1'b0);
    checkOutput("init_rd_gnt", rdGnt, 1'b0);
    tick();
    repeat (4) tick();
    initReq = 1'b1;
    tick();
    initReq = 1'b0;
    countBusy(n);
    checkOutput("init_req_ignored_cycles", n, 10);
    checkOutput("retry_wr_gnt", wrGnt, 1'b1);
    tick();
    readAndCheck("retry_idx9", 4'd9, 4'hF, DATA_E, 4'h0);
    readAndCheck("sweep_clr_idx5", 4'd5, 4'hF, 128'h0, 4'h0);

    // Reset arriving in sweep cycle 9 restarts the sweep from index 0.
    rst_b = 1'b0;
    tick();
    tick();
    rst_b = 1'b1;
    repeat (9) tick();
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    countBusy(n);
    checkOutput("midsweep_reset_cycles", n, 16);
    tick();
    readAndCheck("reset_clr_idx15", 4'd15, 4'hF, 128'h0, 4'h0);

`ifdef ICACHE_DATA_PARITY_EN
    dut.g_bank[1].u_bank.mem_q[2][0] <= ~dut.g_bank[1].u_bank.mem_q[2][0];
    modelMem[1][2][0] = ~modelMem[1][2][0];
    corrupt[1][2]     = 1;
    readAndCheck("parity_bank1_idx2", 4'd2, 4'hF, 128'h00000000_00000001_00000000_00000000, 4'b0100);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
